// File: rtl/bubble_host_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : bubble_host_reader_if
// Brief    : Request handshake, emulator control and read-data bundle
// Revision : 1.0
// ============================================================================
interface bubble_host_reader_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_bootloop;
  logic       bubble_shift_enable;
  logic       replicator_enable;
  logic       bootloop_enable;
  logic       bubble_out_odd;
  logic       bubble_out_even;
  logic [7:0] data_out;
  logic       data_valid;
  logic       page_done;
  logic       busy;

  modport master (
    input  req_valid, req_bootloop, bubble_out_odd, bubble_out_even,
    output req_ready, bubble_shift_enable, replicator_enable, bootloop_enable,
           data_out, data_valid, page_done, busy
  );

  modport slave (
    output req_valid, req_bootloop, bubble_out_odd, bubble_out_even,
    input  req_ready, bubble_shift_enable, replicator_enable, bootloop_enable,
           data_out, data_valid, page_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/bubble_host_reader.sv
`default_nettype none
// ============================================================================
// Module   : bubble_host_reader
// Brief    : Page-access waveform sequencer that samples and packs emulator data
// Revision : 1.0
// ============================================================================
module bubble_host_reader #(
  parameter int REPL_DELAY    = 500,
  parameter int REPL_WIDTH    = 341,
  parameter int SHIFT_HOLD    = 336992,
  parameter int SAMPLE_OFFSET = 64,
  parameter int BIT_PERIOD    = 1000,
  parameter int PAGE_PAIRS    = 256,
  parameter int GAP_CYCLES    = 37500
) (
  input logic                  master_clock,
  input logic                  power_good,
  bubble_host_reader_if.master bus
);

  localparam int c_MAX_A    = (REPL_DELAY > REPL_WIDTH) ? REPL_DELAY : REPL_WIDTH;
  localparam int c_MAX_B    = (SHIFT_HOLD > GAP_CYCLES) ? SHIFT_HOLD : GAP_CYCLES;
  localparam int c_CNT_MAX  = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);
  localparam int c_TICK_MAX = (SAMPLE_OFFSET > BIT_PERIOD) ? SAMPLE_OFFSET : BIT_PERIOD;
  localparam int c_TICK_W   = $clog2(c_TICK_MAX + 1);
  localparam int c_PAIR_W   = $clog2(PAGE_PAIRS + 1);

  localparam logic [c_CNT_W-1:0]  c_LEAD_END   = c_CNT_W'(REPL_DELAY - 1);
  localparam logic [c_CNT_W-1:0]  c_REPL_END   = c_CNT_W'(REPL_WIDTH - 1);
  localparam logic [c_CNT_W-1:0]  c_HOLD_END   = c_CNT_W'(SHIFT_HOLD);
  localparam logic [c_CNT_W-1:0]  c_GAP_END    = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_FIRST = c_TICK_W'(SAMPLE_OFFSET);
  localparam logic [c_TICK_W-1:0] c_TICK_NEXT  = c_TICK_W'(BIT_PERIOD - 1);
  localparam logic [c_PAIR_W-1:0] c_PAIRS      = c_PAIR_W'(PAGE_PAIRS);
  localparam logic [c_PAIR_W-1:0] c_PAIR_LAST  = c_PAIR_W'(PAGE_PAIRS - 1);

  generate
    if (SAMPLE_OFFSET + (PAGE_PAIRS - 1) * BIT_PERIOD >= SHIFT_HOLD) begin : g_bad_sample_window
      $error("bubble_host_reader: last sample falls at or after shift release");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEAD = 3'd1,
    S_REPL = 3'd2,
    S_HOLD = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_next;
  logic                 w_accept;

  logic                 r_odd_meta, r_odd_sync;
  logic                 r_even_meta, r_even_sync;
  logic [c_TICK_W-1:0]  r_tick;
  logic [c_PAIR_W-1:0]  r_pair;
  logic [1:0]           r_slot;
  logic [7:0]           r_byte;
  logic [7:0]           w_byte_new;
  logic                 w_sample;
  logic                 w_emit;

  logic                 r_req_ready;
  logic                 r_shift_n;
  logic                 r_repl_n;
  logic                 r_boot;
  logic                 r_busy;
  logic                 r_page_done;
  logic                 r_data_valid;
  logic [7:0]           r_data_out;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (bus.req_valid && r_req_ready) begin
          w_accept     = 1'b1;
          w_state_next = S_LEAD;
        end
      end
      S_LEAD: if (r_cnt == c_LEAD_END) begin
        w_state_next = S_REPL;
        w_cnt_next   = '0;
      end
      S_REPL: if (r_cnt == c_REPL_END) begin
        w_state_next = S_HOLD;
        w_cnt_next   = '0;
      end
      // HOLD counter reads cycles elapsed since the replicator release.
      S_HOLD: if (r_cnt == c_HOLD_END) begin
        w_state_next = S_GAP;
        w_cnt_next   = '0;
      end
      S_GAP: if (r_cnt == c_GAP_END) begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge master_clock or negedge power_good) begin
    if (!power_good) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge master_clock or negedge power_good) begin
    if (!power_good) begin
      r_req_ready <= 1'b0;
      r_shift_n   <= 1'b1;
      r_repl_n    <= 1'b1;
      r_boot      <= 1'b0;
      r_busy      <= 1'b0;
      r_page_done <= 1'b0;
    end else begin
      r_req_ready <= (w_state_next == S_IDLE);
      r_shift_n   <= !((w_state_next == S_LEAD) || (w_state_next == S_REPL) ||
                       (w_state_next == S_HOLD));
      r_repl_n    <= (w_state_next != S_REPL);
      r_busy      <= (w_state_next != S_IDLE);
      r_page_done <= (w_state_next == S_GAP) && (w_cnt_next == c_GAP_END);
      if (w_accept) begin
        r_boot <= bus.req_bootloop;
      end else if (w_state_next == S_IDLE) begin
        r_boot <= 1'b0;
      end
    end
  end

  always_comb begin
    w_sample   = (r_state == S_HOLD) && (r_tick == '0) && (r_pair != c_PAIRS);
    w_byte_new = r_byte | ({6'b0, r_even_sync, r_odd_sync} << {r_slot, 1'b0});
    w_emit     = w_sample && ((r_slot == 2'd3) || (r_pair == c_PAIR_LAST));
  end

  always_ff @(posedge master_clock or negedge power_good) begin
    if (!power_good) begin
      r_odd_meta   <= 1'b0;
      r_odd_sync   <= 1'b0;
      r_even_meta  <= 1'b0;
      r_even_sync  <= 1'b0;
      r_tick       <= '0;
      r_pair       <= '0;
      r_slot       <= 2'd0;
      r_byte       <= 8'h00;
      r_data_valid <= 1'b0;
      r_data_out   <= 8'h00;
    end else begin
      r_odd_meta  <= bus.bubble_out_odd;
      r_odd_sync  <= r_odd_meta;
      r_even_meta <= bus.bubble_out_even;
      r_even_sync <= r_even_meta;

      if (r_state != S_HOLD) begin
        r_tick <= c_TICK_FIRST;
      end else if (w_sample) begin
        r_tick <= c_TICK_NEXT;
      end else if (r_tick != '0) begin
        r_tick <= r_tick - 1'b1;
      end

      // Emitting clears the byte so a short final byte is zero-filled above.
      if (w_accept) begin
        r_pair <= '0;
        r_slot <= 2'd0;
        r_byte <= 8'h00;
      end else if (w_sample) begin
        r_pair <= r_pair + 1'b1;
        r_slot <= w_emit ? 2'd0 : r_slot + 2'd1;
        r_byte <= w_emit ? 8'h00 : w_byte_new;
      end

      r_data_valid <= w_emit;
      if (w_emit) begin
        r_data_out <= w_byte_new;
      end
    end
  end

  assign bus.req_ready           = r_req_ready;
  assign bus.bubble_shift_enable = r_shift_n;
  assign bus.replicator_enable   = r_repl_n;
  assign bus.bootloop_enable     = r_boot;
  assign bus.busy                = r_busy;
  assign bus.page_done           = r_page_done;
  assign bus.data_valid          = r_data_valid;
  assign bus.data_out            = r_data_out;

endmodule
`default_nettype wire
